riscv_trace_buf: RTL

//  Parametrised commit-trace capture buffer for the riscv core: records one entry
//  per retired instruction (PC, instruction word, packed control bits) in a circular
//  RAM, stops a programmable number of samples after a trigger, then streams the

---
 rtl/riscv_trace_buf.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/riscv_trace_buf.sv
// Commit-trace capture buffer: circular RAM of retired {pc,instr,ctrl} samples,
// frozen a fixed number of samples after a trigger and streamed out oldest-first.
module riscv_trace_buf #(
  parameter int unsigned PC_W      = 32,
  parameter int unsigned INSTR_W   = 32,
  parameter int unsigned CTRL_W    = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned POST_TRIG = 8
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic                              i_in_valid,
  input  logic [PC_W-1:0]                   i_in_pc,
  input  logic [INSTR_W-1:0]                i_in_instr,
  input  logic [CTRL_W-1:0]                 i_in_ctrl,
  input  logic                              i_arm,
  input  logic                              i_trig_ext,
  input  logic                              i_trig_pc_en,
  input  logic [PC_W-1:0]                   i_trig_pc,
  input  logic                              i_rd_req,
  output logic                              o_rd_valid,
  output logic [PC_W+INSTR_W+CTRL_W-1:0]    o_rd_data,
  output logic                              o_rd_last,
  output logic [1:0]                        o_state,
  output logic [$clog2(DEPTH):0]            o_count,
  output logic                              o_overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned DW = PC_W + INSTR_W + CTRL_W;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StArmed = 2'd1,
    StPost  = 2'd2,
    StDone  = 2'd3
  } state_e;

  state_e          r_state, w_state_nxt;
  logic [AW-1:0]   r_wr_ptr, w_wr_ptr_nxt;
  logic [AW-1:0]   r_post_cnt, w_post_cnt_nxt;
  logic [CW-1:0]   r_count, w_count_nxt;
  logic [CW-1:0]   r_rd_cnt, w_rd_cnt_nxt;
  logic            r_overflow, w_overflow_nxt;
  logic            r_rd_valid, w_rd_valid_nxt;
  logic            r_rd_last, w_rd_last_nxt;
  logic [DW-1:0]   r_rd_data, w_rd_data_nxt;
  logic [DW-1:0]   r_mem [DEPTH];

  logic            w_trig;
  logic            w_wr_en;
  logic            w_full;
  logic [AW-1:0]   w_rd_addr;
  logic [DW-1:0]   w_wr_data;

  assign w_trig    = i_trig_ext | (i_trig_pc_en & i_in_valid & (i_in_pc == i_trig_pc));
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_wr_en   = !i_arm && i_in_valid && ((r_state == StArmed) || (r_state == StPost));
  assign w_wr_data = {i_in_pc, i_in_instr, i_in_ctrl};
  // Once wrapped, the oldest surviving entry sits at the frozen write pointer.
  assign w_rd_addr = (r_overflow ? r_wr_ptr : '0) + r_rd_cnt[AW-1:0];

  always_comb begin
    w_state_nxt    = r_state;
    w_wr_ptr_nxt   = r_wr_ptr;
    w_post_cnt_nxt = r_post_cnt;
    w_count_nxt    = r_count;
    w_rd_cnt_nxt   = r_rd_cnt;
    w_overflow_nxt = r_overflow;
    w_rd_valid_nxt = 1'b0;
    w_rd_last_nxt  = 1'b0;
    w_rd_data_nxt  = r_rd_data;

    if (w_wr_en) begin
      w_wr_ptr_nxt = r_wr_ptr + AW'(1);
      if (w_full) begin
        w_overflow_nxt = 1'b1;
      end else begin
        w_count_nxt = r_count + CW'(1);
      end
    end

    if (i_arm) begin
      w_state_nxt    = StArmed;
      w_wr_ptr_nxt   = '0;
      w_post_cnt_nxt = '0;
      w_count_nxt    = '0;
      w_rd_cnt_nxt   = '0;
      w_overflow_nxt = 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
        end
        StArmed: begin
          if (w_trig) begin
            w_post_cnt_nxt = '0;
            w_state_nxt    = (POST_TRIG == 0) ? StDone : StPost;
          end
        end
        StPost: begin
          if (w_wr_en) begin
            w_post_cnt_nxt = r_post_cnt + AW'(1);
            if ((r_post_cnt + AW'(1)) == AW'(POST_TRIG)) begin
              w_state_nxt = StDone;
            end
          end
        end
        StDone: begin
          if (i_rd_req) begin
            if (r_count == '0) begin
              w_state_nxt = StIdle;
            end else begin
              w_rd_valid_nxt = 1'b1;
              w_rd_data_nxt  = r_mem[w_rd_addr];
              w_rd_cnt_nxt   = r_rd_cnt + CW'(1);
              if ((r_rd_cnt + CW'(1)) == r_count) begin
                w_rd_last_nxt = 1'b1;
                w_state_nxt   = StIdle;
              end
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= StIdle;
      r_wr_ptr   <= '0;
      r_post_cnt <= '0;
      r_count    <= '0;
      r_rd_cnt   <= '0;
      r_overflow <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wr_ptr   <= w_wr_ptr_nxt;
      r_post_cnt <= w_post_cnt_nxt;
      r_count    <= w_count_nxt;
      r_rd_cnt   <= w_rd_cnt_nxt;
      r_overflow <= w_overflow_nxt;
      r_rd_valid <= w_rd_valid_nxt;
      r_rd_last  <= w_rd_last_nxt;
      r_rd_data  <= w_rd_data_nxt;
    end
  end

  // Trace RAM carries no reset so it can map onto block memory.
  always_ff @(posedge i_clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= w_wr_data;
    end
  end

  assign o_rd_valid = r_rd_valid;
  assign o_rd_data  = r_rd_data;
  assign o_rd_last  = r_rd_last;
  assign o_state    = r_state;
  assign o_count    = r_count;
  assign o_overflow = r_overflow;

endmodule
